// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode and instruction-class constants for the branch resolve path.
// The opcodes are the RV32 major opcodes that the static predictor decodes.
package branch_resolve_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CLS_OTHER = 2'd0;
  localparam logic [1:0] CLS_BR    = 2'd1;
  localparam logic [1:0] CLS_JAL   = 2'd2;
  localparam logic [1:0] CLS_JALR  = 2'd3;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: early ID redirect for predicted-taken BRANCH/JAL, EX-side
// correction of mispredictions and JALR targets, plus bring-up statistics counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             id_valid_i,
  input  logic [6:0]       id_op_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic             id_pred_taken_i,
  input  logic             ex_cond_i,
  input  logic [XLEN-1:0]  ex_alu_res_i,
  input  logic             cnt_clr_i,
  output logic             id_redirect_o,
  output logic [XLEN-1:0]  id_target_o,
  output logic             ex_redirect_o,
  output logic [XLEN-1:0]  ex_redirect_pc_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic [1:0]      cls_p0;
  logic            pred_p0;
  logic            early_p0;
  logic [XLEN-1:0] tgt_p0;
  logic [XLEN-1:0] pc4_p0;

  logic            vld_p1;
  logic [1:0]      cls_p1;
  logic            pred_p1;
  logic [XLEN-1:0] tgt_p1;
  logic [XLEN-1:0] pc4_p1;

  logic            retire_p1;
  logic            mis_p1;
  logic [XLEN-1:0] fix_pc_p1;

  // ---- ID stage: classify, qualify prediction, compute targets ----
  always_comb begin
    case (id_op_i)
      OP_BRANCH: cls_p0 = CLS_BR;
      OP_JAL:    cls_p0 = CLS_JAL;
      OP_JALR:   cls_p0 = CLS_JALR;
      default:   cls_p0 = CLS_OTHER;
    endcase
  end

  // SYSTEM is flagged taken by the predictor but lands in CLS_OTHER and is dropped here.
  assign pred_p0  = id_pred_taken_i & (cls_p0 != CLS_OTHER);
  assign early_p0 = pred_p0 & ((cls_p0 == CLS_BR) | (cls_p0 == CLS_JAL));
  assign tgt_p0   = id_pc_i + id_imm_i;
  assign pc4_p0   = id_pc_i + {{(XLEN-3){1'b0}}, 3'd4};

  assign id_redirect_o = rst & id_valid_i & early_p0 & ~stall_i & ~ex_redirect_o;
  assign id_target_o   = rst ? tgt_p0 : '0;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (!stall_i) begin
      vld_p1 <= id_valid_i & ~ex_redirect_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall_i) begin
      cls_p1  <= cls_p0;
      pred_p1 <= pred_p0;
      tgt_p1  <= tgt_p0;
      pc4_p1  <= pc4_p0;
    end
  end

  // ---- EX stage: resolve and correct ----
  always_comb begin
    mis_p1    = 1'b0;
    fix_pc_p1 = '0;
    case (cls_p1)
      CLS_BR: begin
        mis_p1    = pred_p1 ^ ex_cond_i;
        fix_pc_p1 = pred_p1 ? pc4_p1 : tgt_p1;
      end
      CLS_JALR: begin
        mis_p1    = 1'b1;
        fix_pc_p1 = ex_alu_res_i & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: begin
        mis_p1    = 1'b0;
        fix_pc_p1 = '0;
      end
    endcase
  end

  // A stalled EX instruction keeps its pending mispredict until the stall clears.
  assign retire_p1        = vld_p1 & ~stall_i;
  assign ex_redirect_o    = retire_p1 & mis_p1;
  assign ex_redirect_pc_o = ex_redirect_o ? fix_pc_p1 : '0;

  assign flush_ifid_o = ex_redirect_o | id_redirect_o;
  assign flush_idex_o = ex_redirect_o;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire_p1 & (cls_p1 == CLS_BR)),
    .clr (cnt_clr_i),
    .cnt (branch_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ex_redirect_o),
    .clr (cnt_clr_i),
    .cnt (mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with a queue-based scoreboard:
// the driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, id_valid_i, id_pred_taken_i, ex_cond_i, cnt_clr_i;
  logic [6:0]  id_op_i;
  logic [31:0] id_pc_i, id_imm_i, ex_alu_res_i;
  logic        id_redirect_o, ex_redirect_o, flush_ifid_o, flush_idex_o;
  logic [31:0] id_target_o, ex_redirect_pc_o;
  logic [3:0]  branch_cnt_o, mispred_cnt_o;

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .id_valid_i       (id_valid_i),
    .id_op_i          (id_op_i),
    .id_pc_i          (id_pc_i),
    .id_imm_i         (id_imm_i),
    .id_pred_taken_i  (id_pred_taken_i),
    .ex_cond_i        (ex_cond_i),
    .ex_alu_res_i     (ex_alu_res_i),
    .cnt_clr_i        (cnt_clr_i),
    .id_redirect_o    (id_redirect_o),
    .id_target_o      (id_target_o),
    .ex_redirect_o    (ex_redirect_o),
    .ex_redirect_pc_o (ex_redirect_pc_o),
    .flush_ifid_o     (flush_ifid_o),
    .flush_idex_o     (flush_idex_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        idr;
    logic [31:0] tgt;
    logic        exr;
    logic [31:0] expc;
    logic        fi;
    logic        fx;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vid   = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("id_redirect", e.id, {31'd0, id_redirect_o}, {31'd0, e.idr});
      chk("id_target",   e.id, id_target_o, e.tgt);
      chk("ex_redirect", e.id, {31'd0, ex_redirect_o}, {31'd0, e.exr});
      if (e.exr) chk("ex_redirect_pc", e.id, ex_redirect_pc_o, e.expc);
      chk("flush_ifid",  e.id, {31'd0, flush_ifid_o}, {31'd0, e.fi});
      chk("flush_idex",  e.id, {31'd0, flush_idex_o}, {31'd0, e.fx});
      chk("branch_cnt",  e.id, {28'd0, branch_cnt_o}, {28'd0, e.bc});
      chk("mispred_cnt", e.id, {28'd0, mispred_cnt_o}, {28'd0, e.mc});
    end
  end

  // Apply one cycle of inputs and queue the outputs expected before the next edge.
  task automatic vec(input logic r, input logic st, input logic vl, input logic [6:0] op,
                     input logic [31:0] pc, input logic [31:0] imm, input logic pr,
                     input logic cd, input logic [31:0] alu, input logic clr,
                     input logic idr, input logic [31:0] tgt, input logic exr,
                     input logic [31:0] expc, input logic fi, input logic fx,
                     input int bc, input int mc);
    exp_t e;
    rst = r; stall_i = st; id_valid_i = vl; id_op_i = op; id_pc_i = pc;
    id_imm_i = imm; id_pred_taken_i = pr; ex_cond_i = cd; ex_alu_res_i = alu;
    cnt_clr_i = clr;
    e.id = vid; e.idr = idr; e.tgt = tgt; e.exr = exr; e.expc = expc;
    e.fi = fi; e.fx = fx; e.bc = 4'(bc); e.mc = 4'(mc);
    q.push_back(e);
    vid++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic cd, input logic [31:0] alu, input logic clr,
                      input logic exr, input logic [31:0] expc, input int bc, input int mc);
    vec(1, 0, 0, 7'h00, 32'h0, 32'h0, 0, cd, alu, clr, 0, 32'h0, exr, expc, exr, exr, bc, mc);
  endtask

  initial begin
    rst = 1'b0; stall_i = 0; id_valid_i = 0; id_op_i = '0; id_pc_i = '0; id_imm_i = '0;
    id_pred_taken_i = 0; ex_cond_i = 0; ex_alu_res_i = '0; cnt_clr_i = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      vec(0, 1'($urandom), 1'($urandom), (i == 0) ? BR : 7'($urandom), $urandom, $urandom,
          1'($urandom), 1'($urandom), $urandom, 1'($urandom), 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);

    idle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    // Mispredicted taken BRANCH: early redirect, then EX correction to pc+4.
    vec(1, 0, 1, BR, 32'h100, 32'h20, 1, 0, 0, 0, 1, 32'h120, 0, 0, 1, 0, 0, 0);
    idle(0, 32'h0, 0, 1, 32'h104, 0, 0);
    idle(0, 32'h0, 0, 0, 32'h0, 1, 1);
    // Not-taken prediction, branch taken: redirect to target.
    vec(1, 0, 1, BR, 32'h300, 32'h40, 0, 0, 0, 0, 0, 32'h340, 0, 0, 0, 0, 1, 1);
    idle(1, 32'h0, 0, 1, 32'h340, 1, 1);
    // Correct taken prediction: no EX redirect.
    vec(1, 0, 1, BR, 32'h400, 32'h8, 1, 0, 0, 0, 1, 32'h408, 0, 0, 1, 0, 2, 2);
    idle(1, 32'h0, 0, 0, 32'h0, 2, 2);
    // JAL with negative offset, followed by JALR.
    vec(1, 0, 1, JAL, 32'h200, 32'hFFFFFFF0, 1, 0, 0, 0, 1, 32'h1F0, 0, 0, 1, 0, 3, 2);
    vec(1, 0, 1, JALR, 32'h500, 32'h0, 1, 0, 0, 0, 0, 32'h500, 0, 0, 0, 0, 3, 2);
    idle(0, 32'h00000337, 0, 1, 32'h336, 3, 2);
    // SYSTEM flagged taken is ignored.
    vec(1, 0, 1, SYS, 32'h600, 32'h10, 1, 0, 0, 0, 0, 32'h610, 0, 0, 0, 0, 3, 3);
    idle(0, 32'h0, 0, 0, 32'h0, 3, 3);
    idle(0, 32'h0, 0, 0, 32'h0, 3, 3);
    // Mispredict held under a 3-cycle stall, released alongside a predicted-taken ID branch.
    vec(1, 0, 1, BR, 32'h700, 32'h10, 0, 0, 0, 0, 0, 32'h710, 0, 0, 0, 0, 3, 3);
    for (int i = 0; i < 3; i++)
      vec(1, 1, 1, BR, 32'h800, 32'h20, 1, 1, 0, 0, 0, 32'h820, 0, 0, 0, 0, 3, 3);
    vec(1, 0, 1, BR, 32'h800, 32'h20, 1, 1, 0, 0, 0, 32'h820, 1, 32'h710, 1, 1, 3, 3);
    idle(0, 32'h0, 0, 0, 32'h0, 4, 4);
    idle(0, 32'h0, 0, 0, 32'h0, 4, 4);
    // Clear, then saturate both counters with 17 mispredicts.
    idle(0, 32'h0, 1, 0, 32'h0, 4, 4);
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i > 15) ? 15 : i;
      vec(1, 0, 1, BR, 32'h1000, 32'h40, 1, 0, 0, 0, 1, 32'h1040, 0, 0, 1, 0, c, c);
      idle(0, 32'h0, 0, 1, 32'h1004, c, c);
    end
    vec(1, 0, 1, BR, 32'h1000, 32'h40, 1, 0, 0, 0, 1, 32'h1040, 0, 0, 1, 0, 15, 15);
    idle(0, 32'h0, 1, 1, 32'h1004, 15, 15);
    idle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    // Reset while a mispredict is pending under stall discards it.
    vec(1, 0, 1, BR, 32'h900, 32'h10, 0, 0, 0, 0, 0, 32'h910, 0, 0, 0, 0, 0, 0);
    vec(1, 1, 0, 7'h00, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    vec(0, 0, 0, 7'h00, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    vec(1, 0, 0, 7'h00, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
